// File: rtl/rv523_bus_pkg.sv
// Shared types and constants for the rv523 load-store bus responder.
// Holds the responder FSM encoding, lane geometry and error codes.
package rv523_bus_pkg;

    localparam int WORD_W     = 32;
    localparam int LANE_W     = 8;
    localparam int LANES      = WORD_W / LANE_W;
    localparam int ALIGN_BITS = 2;

    localparam logic ERR_OK    = 1'b0;
    localparam logic ERR_FAULT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned, or any set bit above the word index: upper bits never wrap.
    function automatic logic addr_fault(input logic [WORD_W-1:0] addr, input int idx_w);
        return (addr[ALIGN_BITS-1:0] != '0) || ((addr >> (idx_w + ALIGN_BITS)) != '0);
    endfunction

endpackage

// File: rtl/rv523_sram_array.sv
// Single-port word storage with per-byte-lane write enables.
// Writes are synchronous; reads are combinational from the addressed word.
module rv523_sram_array
    import rv523_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [LANES-1:0]  i_wstrb,
    output logic [WORD_W-1:0] o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] r_lane [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (i_we && i_wstrb[gi]) begin
                    r_lane[i_idx] <= i_wdata[gi*LANE_W +: LANE_W];
                end
            end

            assign o_rdata[gi*LANE_W +: LANE_W] = r_lane[i_idx];
        end
    endgenerate

endmodule

// File: rtl/rv523_mem_responder.sv
// Target end of the core's valid/ready load-store bus: accepts one request,
// waits WAIT_CYCLES, then holds the response until the initiator takes it.
module rv523_mem_responder
    import rv523_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt;
    logic [WORD_W-1:0] r_addr, r_wdata, r_rdata;
    logic [LANES-1:0]  r_wstrb;
    logic              r_we, r_err;

    logic              w_accept, w_enter_resp, w_mem_we;
    logic              w_cur_we, w_cur_err;
    logic [WORD_W-1:0] w_cur_addr, w_cur_wdata, w_mem_rdata;
    logic [LANES-1:0]  w_cur_wstrb;

    assign w_accept = req_valid && req_ready;

    // With no wait state the RESP edge is the accept edge, so storage sees the live request.
    assign w_cur_addr   = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata  = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_cur_wstrb  = (r_state == ST_IDLE) ? req_wstrb : r_wstrb;
    assign w_cur_we     = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_cur_err    = addr_fault(w_cur_addr, IDX_W);
    assign w_enter_resp = (r_state != ST_RESP) && (w_state_next == ST_RESP);
    assign w_mem_we     = rst_n && w_enter_resp && w_cur_we && !w_cur_err;

    rv523_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk    (clk),
        .i_we   (w_mem_we),
        .i_idx  (w_cur_addr[IDX_W+1:2]),
        .i_wdata(w_cur_wdata),
        .i_wstrb(w_cur_wstrb),
        .o_rdata(w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0) w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= ERR_OK;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_we    <= req_we;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_cur_err ? ERR_FAULT : ERR_OK;
                r_rdata <= (w_cur_we || w_cur_err) ? '0 : w_mem_rdata;
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_rv523_mem_responder.sv
// Directed bench for rv523_mem_responder: data path, errors, backpressure,
// latency for WAIT_CYCLES 0/1/3, and reset in the middle of a write.
module tb_rv523_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        v0, v3;
    logic        rdy0, rdy3, val0, val3, err0, err3;
    logic [31:0] rd0, rd3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv523_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    rv523_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(val0), .rsp_ready(1'b1), .rsp_rdata(rd0), .rsp_err(err0)
    );

    rv523_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(val3), .rsp_ready(1'b1), .rsp_rdata(rd3), .rsp_err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on u_dut; consumes the response only if rsp_ready is high.
    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int lat, output logic [31:0] rd,
                       output logic e);
        chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_we = we; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = ~d; req_wstrb = 4'hF;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        $display("txn we=%0d addr=0x%08h wdata=0x%08h wstrb=%b -> lat=%0d rdata=0x%08h err=%0d",
                 we, a, d, s, lat, rd, e);
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; rsp_ready = 1'b1; v0 = 1'b0; v3 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Full write then read back
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd, e);
        chk("wr10_lat", lat, 32'd1);
        chk("wr10_err", {31'd0, e}, 32'd0);
        chk("wr10_rdata", rd, 32'd0);
        chk("wr10_idle_after", {31'd0, req_ready}, 32'd1);
        chk("wr10_valid_drop", {31'd0, rsp_valid}, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
        chk("rd10_lat", lat, 32'd1);
        chk("rd10_rdata", rd, 32'hDEADBEEF);
        chk("rd10_err", {31'd0, e}, 32'd0);

        // Partial lane write
        txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, rd, e);
        chk("wr10_part_err", {31'd0, e}, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
        chk("rd10_part_rdata", rd, 32'hDEADBEAA);

        // Upper-lane partial write to another word, seeded first
        txn(1'b1, 32'h20, 32'h11223344, 4'b1111, lat, rd, e);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b1100, lat, rd, e);
        txn(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, e);
        chk("rd20_upper_lanes", rd, 32'hAABB3344);

        // Misaligned and out-of-range
        txn(1'b0, 32'h12, 32'h0, 4'b0000, lat, rd, e);
        chk("rd12_err", {31'd0, e}, 32'd1);
        chk("rd12_rdata", rd, 32'd0);
        txn(1'b1, 32'h0, 32'h11112222, 4'b1111, lat, rd, e);
        txn(1'b1, 32'h400, 32'h12345678, 4'b1111, lat, rd, e);
        chk("wr400_err", {31'd0, e}, 32'd1);
        txn(1'b0, 32'h400, 32'h0, 4'b0000, lat, rd, e);
        chk("rd400_err", {31'd0, e}, 32'd1);
        chk("rd400_rdata", rd, 32'd0);
        txn(1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, e);
        chk("rd0_no_alias", rd, 32'h11112222);
        txn(1'b1, 32'h13, 32'hFFFFFFFF, 4'b1111, lat, rd, e);
        chk("wr13_err", {31'd0, e}, 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
        chk("rd10_after_bad_wr", rd, 32'hDEADBEAA);

        // Zero strobe is a legal no-op
        txn(1'b1, 32'h10, 32'h55555555, 4'b0000, lat, rd, e);
        chk("wr10_nostrb_err", {31'd0, e}, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
        chk("rd10_nostrb", rd, 32'hDEADBEAA);

        // Last legal word
        txn(1'b1, 32'h3FC, 32'hCAFEF00D, 4'b1111, lat, rd, e);
        chk("wr3fc_err", {31'd0, e}, 32'd0);
        txn(1'b0, 32'h3FC, 32'h0, 4'b0000, lat, rd, e);
        chk("rd3fc_rdata", rd, 32'hCAFEF00D);

        // Backpressure: response held for 5 cycles
        rsp_ready = 1'b0;
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
        chk("bp_rdata", rd, 32'hDEADBEAA);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata_held", rsp_rdata, 32'hDEADBEAA);
            chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_idle", {31'd0, req_ready}, 32'd1);

        // Latency with WAIT_CYCLES=0 and 3
        req_we = 1'b0; req_addr = 32'h0; req_wstrb = 4'b0000;
        chk("w0_valid_before", {31'd0, val0}, 32'd0);
        chk("w0_ready_before", {31'd0, rdy0}, 32'd1);
        v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        chk("w0_valid_at_n1", {31'd0, val0}, 32'd1);
        chk("w0_err", {31'd0, err0}, 32'd0);
        @(posedge clk); #1;
        chk("w3_ready_before", {31'd0, rdy3}, 32'd1);
        v3 = 1'b1;
        @(posedge clk); #1;
        v3 = 1'b0;
        lat = 0;
        while (!val3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("latency WAIT_CYCLES=3 -> %0d edges after accept", lat);
        chk("w3_lat", lat, 32'd3);

        // Reset while a write sits in WAIT
        chk("rstmid_ready_before", {31'd0, req_ready}, 32'd1);
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BADF00D; req_wstrb = 4'b1111;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_ready_low", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_ready_after", {31'd0, req_ready}, 32'd1);
        chk("rstmid_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
        chk("rstmid_word_kept", rd, 32'hDEADBEAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv523_mem_responder.md
RV523_MEM_RESPONDER -- requirements
Module: rv523_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of 2, 4..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the extra cycles between request accept and response (0..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder accepts a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_wstrb  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator takes the response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The block SHALL be the target (responder) end of the core's valid/ready load-store bus, with a three-state FSM: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-017 On accept, addr, we, wdata, wstrb SHALL be captured; later changes on req_* SHALL have no effect on that transaction.
REQ-018 On accept, IDLE SHALL go to WAIT with the wait counter loaded with WAIT_CYCLES-1 if WAIT_CYCLES>0, else directly to RESP.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP when the counter is 0.
REQ-020 Latency: a request accepted at edge N SHALL produce rsp_valid=1 from edge N+1+WAIT_CYCLES.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; then next state is IDLE.
REQ-022 No request SHALL be accepted in the same cycle a response is consumed (max one transaction per 2+WAIT_CYCLES cycles).
REQ-023 Error: req_addr[1:0]!=0 or word index >= DEPTH_WORDS (byte address >= 4*DEPTH_WORDS) SHALL set rsp_err=1, rsp_rdata=0, and leave storage unchanged.
REQ-024 A valid write SHALL update only lanes with wstrb=1, at the edge entering RESP; wstrb=0000 SHALL be a legal no-op with rsp_err=0.
REQ-025 A valid read SHALL return the word as stored at the edge entering RESP, including any prior completed write to the same word.
REQ-026 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be checked only for the range error, never wrapped.

Reset
REQ-027 With rst_n=0 at a rising edge, state SHALL become IDLE, counter 0, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 Reset mid-transaction SHALL abandon it with no storage write and no response; the first cycle after reset release SHALL show req_ready=1.
REQ-029 Storage contents SHALL NOT be reset.

Structure
REQ-030 The FSM state enum and the error/lane-width constants SHALL live in shared package rv523_bus_pkg.
REQ-031 Storage SHALL be one sub-module rv523_sram_array (single port, byte-lane write enables, synchronous write, combinational read).

Verification
REQ-032 WAIT_CYCLES=1: write 0x0000_0010, data 0xDEADBEEF, wstrb 1111 accepted at edge N -> rsp_valid at N+2, rsp_err=0; read 0x10 -> rdata 0xDEADBEEF.
REQ-033 Partial write 0x10 wdata 0x0000_00AA wstrb 0001 after REQ-032 -> read returns 0xDEADBEAA.
REQ-034 Read 0x0000_0012 -> rsp_err=1, rdata 0; read 0x0000_0400 with DEPTH_WORDS=256 -> rsp_err=1, storage unchanged.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; release -> IDLE next cycle.
REQ-036 WAIT_CYCLES=0: accept at N -> rsp_valid at N+1; WAIT_CYCLES=3 -> rsp_valid at N+4.
REQ-037 Assert rst_n=0 in WAIT during a write -> no response, target word keeps old value, req_ready=1 first cycle after release.
